// File: rtl/seg7_scan_display.sv
// Time-multiplexed seven-segment driver: scans N_DIGITS active-low common-anode digits,
// with frame-synchronous double-buffered loads, leading-zero blanking and a guard cycle.
module seg7_scan_lane #(
  parameter int N_DIGITS = 8,
  parameter int IDX      = 0
) (
  input  logic [3:0]          nib,
  input  logic [N_DIGITS-1:0] zero,
  input  logic                mode,
  output logic [6:0]          seg
);
  localparam int HALF = N_DIGITS / 2;

  logic [N_DIGITS-1:0] span;
  logic                is_lsb, blank;

  // span = this digit and every higher digit of its blanking group
  always_comb begin
    span = '0;
    for (int j = 0; j < N_DIGITS; j++)
      if (j >= IDX && !(mode && IDX < HALF && j >= HALF)) span[j] = 1'b1;
    is_lsb = (IDX == 0) || (mode && IDX == HALF);
    blank  = (&(zero | ~span)) && !is_lsb;
  end

  always_comb begin
    case (nib)
      4'h0: seg = 7'h40;  4'h1: seg = 7'h79;  4'h2: seg = 7'h24;  4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;  4'h5: seg = 7'h12;  4'h6: seg = 7'h02;  4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;  4'h9: seg = 7'h10;  4'hA: seg = 7'h08;  4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;  4'hD: seg = 7'h21;  4'hE: seg = 7'h06;  default: seg = 7'h0E;
    endcase
    if (blank) seg = 7'h7F;
  end
endmodule

module seg7_scan_display #(
  parameter int N_DIGITS = 8,
  parameter int DIV      = 100000
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [4*N_DIGITS-1:0] Value,
  input  logic [N_DIGITS-1:0]   DotMask,
  input  logic                  Mode,
  input  logic                  Load,
  output logic                  LoadAck,
  output logic [6:0]            out7,
  output logic                  dp,
  output logic [N_DIGITS-1:0]   en_out
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = $clog2(N_DIGITS);

  typedef struct packed {
    logic [4*N_DIGITS-1:0] value;
    logic [N_DIGITS-1:0]   dots;
    logic                  mode;
  } disp_t;

  disp_t                     shadow, pend, load_in;
  logic                      pend_vld;
  logic [CW-1:0]             divcnt;
  logic [IW-1:0]             idx;
  logic [N_DIGITS-1:0]       zero;
  logic [N_DIGITS-1:0][6:0]  lane_seg;
  logic                      slot_end, frame_end;

  assign load_in   = '{value: Value, dots: DotMask, mode: Mode};
  assign slot_end  = (divcnt == CW'(DIV - 1));
  assign frame_end = slot_end && (idx == IW'(N_DIGITS - 1));

  for (genvar i = 0; i < N_DIGITS; i++) begin : g_lane
    assign zero[i] = (shadow.value[4*i +: 4] == 4'h0);
    seg7_scan_lane #(.N_DIGITS(N_DIGITS), .IDX(i)) u_lane (
      .nib  (shadow.value[4*i +: 4]),
      .zero (zero),
      .mode (shadow.mode),
      .seg  (lane_seg[i])
    );
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      divcnt   <= '0;
      idx      <= '0;
      pend_vld <= 1'b0;
      pend     <= '0;
      shadow   <= '0;
      LoadAck  <= 1'b0;
      out7     <= 7'h7F;
      dp       <= 1'b1;
      en_out   <= '1;
    end else begin
      LoadAck <= 1'b0;
      if (Load) begin
        pend     <= load_in;
        pend_vld <= 1'b1;
      end
      if (slot_end) begin
        divcnt <= '0;
        idx    <= (idx == IW'(N_DIGITS - 1)) ? '0 : idx + 1'b1;
      end else begin
        divcnt <= divcnt + 1'b1;
      end
      // a Load on the boundary cycle bypasses the pending register
      if (frame_end && (Load || pend_vld)) begin
        shadow   <= Load ? load_in : pend;
        pend_vld <= 1'b0;
        LoadAck  <= 1'b1;
      end
      if (slot_end) begin
        en_out <= '1;
        out7   <= 7'h7F;
        dp     <= 1'b1;
      end else begin
        en_out <= ~(N_DIGITS'(1) << idx);
        out7   <= lane_seg[idx];
        dp     <= ~shadow.dots[idx];
      end
    end
  end
endmodule

// File: tb/tb_seg7_scan_display.sv
// Directed bench for seg7_scan_display with N_DIGITS=8, DIV=4 (32-cycle frame).
module tb_seg7_scan_display;
  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic [31:0] Value = '0;
  logic [7:0]  DotMask = '0;
  logic        Mode = 1'b0;
  logic        Load = 1'b0;
  logic        LoadAck;
  logic [6:0]  out7;
  logic        dp;
  logic [7:0]  en_out;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  localparam logic [7:0][6:0] E_RST = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40};
  localparam logic [7:0][6:0] E_T2  = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h08, 7'h79};
  localparam logic [7:0][6:0] E_T3A = {7'h7F, 7'h7F, 7'h79, 7'h24, 7'h7F, 7'h7F, 7'h7F, 7'h30};
  localparam logic [7:0][6:0] E_T3B = {7'h7F, 7'h7F, 7'h7F, 7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h40};
  localparam logic [7:0][6:0] E_T4  = {8{7'h24}};
  localparam logic [7:0][6:0] E_T5  = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h03, 7'h06, 7'h06, 7'h0E};

  seg7_scan_display #(.N_DIGITS(8), .DIV(4)) dut (
    .Clk(Clk), .Rst(Rst), .Value(Value), .DotMask(DotMask), .Mode(Mode),
    .Load(Load), .LoadAck(LoadAck), .out7(out7), .dp(dp), .en_out(en_out)
  );

  always #5 Clk = ~Clk;

  // posedges since reset release; the display seen after edge c reflects slot state c-1
  always @(posedge Clk) cyc <= Rst ? 0 : cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic wait_cnt(input int t);
    int n = 0;
    while (cyc != t && n < 200) begin
      @(negedge Clk);
      n++;
    end
    if (cyc != t) chk("wait_timeout", cyc, t);
  endtask

  task automatic do_load(input logic [31:0] v, input logic [7:0] dm, input logic m);
    Value = v; DotMask = dm; Mode = m; Load = 1'b1;
    @(negedge Clk);
    Load = 1'b0;
  endtask

  // checks one full frame of outputs starting with slot state base
  task automatic run_frame(input int base, input logic [7:0][6:0] es, input logic [7:0] edp,
                           input logic ack_last);
    int s, d;
    logic [7:0] e_en;
    wait_cnt(base + 1);
    for (int k = 1; k <= 32; k++) begin
      s = base + k - 1;
      d = (s / 4) % 8;
      if (s % 4 == 3) begin
        chk("guard_en", en_out, 8'hFF);
        chk("guard_seg", out7, 7'h7F);
        chk("guard_dp", dp, 1'b1);
      end else begin
        e_en = ~(8'h01 << d);
        chk("en", en_out, e_en);
        chk("seg", out7, es[d]);
        chk("dp", dp, edp[d]);
      end
      chk("ack", LoadAck, (k == 32) ? ack_last : 1'b0);
      if (k < 32) @(negedge Clk);
    end
  endtask

  initial begin
    repeat (3) @(negedge Clk);
    chk("rst_seg", out7, 7'h7F);
    chk("rst_dp", dp, 1'b1);
    chk("rst_en", en_out, 8'hFF);
    chk("rst_ack", LoadAck, 1'b0);
    Rst = 1'b0;

    run_frame(0, E_RST, 8'hFF, 1'b0);

    fork
      run_frame(32, E_RST, 8'hFF, 1'b1);
      begin wait_cnt(40); do_load(32'h0000_00A1, 8'h02, 1'b0); end
    join
    run_frame(64, E_T2, 8'hFD, 1'b0);

    fork
      run_frame(96, E_T2, 8'hFD, 1'b1);
      begin wait_cnt(100); do_load(32'h0012_0003, 8'h00, 1'b1); end
    join
    run_frame(128, E_T3A, 8'hFF, 1'b0);

    fork
      run_frame(160, E_T3A, 8'hFF, 1'b1);
      begin wait_cnt(170); do_load(32'h0000_0000, 8'h00, 1'b1); end
    join
    run_frame(192, E_T3B, 8'hFF, 1'b0);

    fork
      run_frame(224, E_T3B, 8'hFF, 1'b1);
      begin
        wait_cnt(230); do_load(32'h1111_1111, 8'hFF, 1'b0);
        wait_cnt(238); do_load(32'h2222_2222, 8'h81, 1'b0);
      end
    join
    run_frame(256, E_T4, 8'h7E, 1'b0);

    fork
      run_frame(288, E_T4, 8'h7E, 1'b1);
      begin wait_cnt(319); do_load(32'h0000_BEEF, 8'h00, 1'b0); end
    join
    run_frame(320, E_T5, 8'hFF, 1'b0);

    wait_cnt(357);
    do_load(32'h5555_5555, 8'hFF, 1'b0);
    wait_cnt(362);
    Rst = 1'b1;
    @(negedge Clk);
    chk("mid_rst_seg", out7, 7'h7F);
    chk("mid_rst_en", en_out, 8'hFF);
    chk("mid_rst_ack", LoadAck, 1'b0);
    @(negedge Clk);
    chk("mid_rst_dp", dp, 1'b1);
    Rst = 1'b0;
    run_frame(0, E_RST, 8'hFF, 1'b0);
    run_frame(32, E_RST, 8'hFF, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #100000;
    chk("global_timeout", 32'd1, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/seg7_scan_display.md
Name: seg7_scan_display

Overview:
- Parametrised time-multiplexed seven-segment driver, successor to the fixed two-number 4+4 digit display path.
- Scans N_DIGITS common-anode digits from one packed hex value and drives Nexys-style active-low segment and anode lines.
- Adds a double-buffered load handshake that updates only at frame boundaries (no tearing), per-digit decimal points, leading-zero blanking (whole or split in two halves), and an anti-ghosting guard cycle.
- Sits between the datapath result registers and the board pins.

Parameters:
N_DIGITS, 8, number of digits scanned; must be even and ≥2
DIV, 100000, Clk cycles per digit slot; must be ≥2

Ports:
Clk  in  1  system clock
Rst  in  1  synchronous reset, active-high
Value  in  4*N_DIGITS  packed hex digits; Value[3:0] is digit 0 (rightmost)
DotMask  in  N_DIGITS  1 = light decimal point of digit i
Mode  in  1  0 = one number across all digits; 1 = two numbers, upper and lower N_DIGITS/2 digits
Load  in  1  1-cycle strobe: capture Value/DotMask/Mode
LoadAck  out  1  1-cycle pulse: captured data now on display
out7  out  7  segments {g,f,e,d,c,b,a}, active-low
dp  out  1  decimal point, active-low
en_out  out  N_DIGITS  digit anodes, active-low, bit i = digit i

Behaviour:
- One clock, Clk. Rst is synchronous and active-high.
- Reset clears the divider counter, the digit index, the pending flag and the pending register. It also clears the shadow register (Value 0, DotMask 0, Mode 0).
- Reset values of the registered outputs: out7=7'h7F, dp=1, en_out=all ones, LoadAck=0.
- Divider divcnt counts 0..DIV-1 and wraps.
  - At divcnt==DIV-1, idx advances; N_DIGITS-1 wraps to 0.
  - A frame is N_DIGITS*DIV cycles.
- All outputs are registered: the values in cycle t+1 reflect divcnt, idx and shadow at cycle t.
- Guard cycle: if divcnt==DIV-1, the next cycle has en_out all ones, out7=7'h7F and dp=1. Otherwise en_out = ~(1<<idx).
- Decode (segment vectors hex):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- Leading-zero blanking (out7=7'h7F):
  - Digit i is blanked when it and every higher digit in its group are 0, except the group's least-significant digit, which always shows.
  - Mode 0: one group, digits N_DIGITS-1..0.
  - Mode 1: two groups, N_DIGITS-1..N_DIGITS/2 and N_DIGITS/2-1..0.
  - dp = ~DotMask[idx], regardless of blanking.
- Load handshake:
  - Load=1 writes Value/DotMask/Mode into the pending register and sets pending. Repeated Loads overwrite; the last one wins.
  - Frame boundary is idx==N_DIGITS-1 and divcnt==DIV-1. At the boundary, if pending (or Load=1 in that same cycle, which bypasses straight to shadow with that cycle's data), the data is copied to shadow and pending is cleared.
  - LoadAck=1 in the next cycle for exactly one cycle. Only one LoadAck is issued per boundary.
  - Shadow never changes mid-frame.
- Rst mid-frame:
  - Discards pending data.
  - Suppresses any LoadAck not yet issued.
  - Restarts at idx 0, divcnt 0.
- After reset, the display shows '0' on digit 0 only (Mode 0, shadow 0).

Test Plan (N_DIGITS=8, DIV=4, frame=32 cycles):
1. Reset and release check.
   - Hold Rst 3 cycles -> out7=7F, dp=1, en_out=FF, LoadAck=0.
   - After release -> en_out=FE with out7=40 for 3 cycles, then one cycle of FF, then FD with out7=7F.
2. Mode 0 hex decode and blanking.
   - Load Value=0x000000A1, DotMask=0x02, Mode 0 -> LoadAck on the cycle after the first boundary.
   - Next frame -> digit0 out7=79; digit1 out7=08 with dp=0; digits 2-7 out7=7F.
3. Mode 1 split blanking.
   - Value=0x00120003 -> digit0=30, digits1-3 blank, digit4=24, digit5=79, digits6-7 blank.
   - Value=0 -> only digits 0 and 4 show 40.
4. Mid-frame loads.
   - Two Loads in the same frame (0x11111111 then 0x22222222) -> displayed digits unchanged until the boundary; then all digits show 24; exactly one LoadAck.
5. Load on the boundary cycle.
   - Load on the exact boundary cycle -> that data is shown in the very next slot; LoadAck the next cycle.
6. Guard cycle and reset mid-frame.
   - Every slot contains exactly one cycle with en_out=FF.
   - Rst while pending -> no LoadAck; the display returns to '0' on digit 0.
